// File: rtl/square_synth_bank.sv
// square_synth_bank: multi-voice square-wave tone generator.
// Per-voice period/volume/duration, level mixer and 1-bit PDM.
module square_synth_bank #(
  parameter int  CHANNELS = 2,
  parameter int  PERIOD_W = 16,
  parameter int  DUR_W    = 12,
  parameter int  VOL_W    = 3,
  localparam int CH_W     =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LEVEL_W  =
    VOL_W + $clog2(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SAMPLE_TRIGGER,
  input  logic                CMD_VALID,
  input  logic [CH_W-1:0]     CMD_CHANNEL,
  input  logic [PERIOD_W-1:0] CMD_HALF_PERIOD,
  input  logic [DUR_W-1:0]    CMD_DURATION,
  input  logic [VOL_W-1:0]    CMD_VOLUME,
  output logic [CHANNELS-1:0] ACTIVE,
  output logic [CHANNELS-1:0] DONE,
  output logic [LEVEL_W-1:0]  AUDIO_LEVEL,
  output logic                AUDIO
);

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  logic [CHANNELS-1:0] phase_vec;
  logic [VOL_W-1:0]    vol_arr [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic [PERIOD_W-1:0] cur_half_q, cur_half_d;
    logic [PERIOD_W-1:0] pend_half_q, pend_half_d;
    logic [DUR_W-1:0]    remaining_q, remaining_d;
    logic [VOL_W-1:0]    volume_q, volume_d;
    logic                phase_q, phase_d;
    logic                done_q, done_d;
    logic                hit;

    assign hit = CMD_VALID &&
      (CMD_CHANNEL == CH_W'(g));

    // Voice next state: trigger advance first, command load on top
    always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      cur_half_d  = cur_half_q;
      pend_half_d = pend_half_q;
      remaining_d = remaining_q;
      volume_d    = volume_q;
      phase_d     = phase_q;
      done_d      = 1'b0;
      if (state_q == S_PLAY && SAMPLE_TRIGGER) begin
        if (tick_q == cur_half_q) begin
          tick_d     = '0;
          cur_half_d = pend_half_q;
          phase_d    = (pend_half_q == '0) ?
                       1'b0 : ~phase_q;
        end else begin
          tick_d = tick_q + PERIOD_W'(1);
        end
        remaining_d = remaining_q - DUR_W'(1);
        if (remaining_q == DUR_W'(1) && !hit) begin
          state_d = S_IDLE;
          tick_d  = '0;
          phase_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      if (hit) begin
        if (CMD_DURATION == '0) begin
          state_d = S_IDLE;
          tick_d  = '0;
          phase_d = 1'b0;
        end else if (state_q == S_IDLE) begin
          state_d     = S_PLAY;
          tick_d      = '0;
          cur_half_d  = CMD_HALF_PERIOD;
          pend_half_d = CMD_HALF_PERIOD;
          remaining_d = CMD_DURATION;
          volume_d    = CMD_VOLUME;
          phase_d     = (CMD_HALF_PERIOD != '0);
        end else begin
          pend_half_d = CMD_HALF_PERIOD;
          remaining_d = CMD_DURATION;
          volume_d    = CMD_VOLUME;
        end
      end
    end

    // Voice state registers
    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q     <= S_IDLE;
        tick_q      <= '0;
        cur_half_q  <= '0;
        pend_half_q <= '0;
        remaining_q <= '0;
        volume_q    <= '0;
        phase_q     <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        tick_q      <= tick_d;
        cur_half_q  <= cur_half_d;
        pend_half_q <= pend_half_d;
        remaining_q <= remaining_d;
        volume_q    <= volume_d;
        phase_q     <= phase_d;
        done_q      <= done_d;
      end
    end

    assign ACTIVE[g]    = (state_q == S_PLAY);
    assign DONE[g]      = done_q;
    assign phase_vec[g] = phase_q;
    assign vol_arr[g]   = volume_q;
  end

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] acc_q, acc_d;
  logic               audio_q, audio_d;

  // Sum the volumes of all voices whose phase is high
  always_comb begin
    level_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (phase_vec[i]) begin
        level_d = level_d + LEVEL_W'(vol_arr[i]);
      end
    end
  end

  // First-order PDM: carry out of the accumulator is the pin
  always_comb begin
    {audio_d, acc_d} = {1'b0, acc_q} +
                       {1'b0, level_q};
  end

  // Mixer and modulator registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      level_q <= '0;
      acc_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      level_q <= level_d;
      acc_q   <= acc_d;
      audio_q <= audio_d;
    end
  end

  assign AUDIO_LEVEL = level_q;
  assign AUDIO       = audio_q;

endmodule

// File: tb/tb_square_synth_bank.sv
// tb_square_synth_bank: directed stimulus with a cycle-stamped
// expectation queue drained by a falling-edge monitor.
module tb_square_synth_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        cmd_valid;
  logic        cmd_valid3;
  logic [0:0]  cmd_ch;
  logic [1:0]  cmd_ch3;
  logic [15:0] cmd_half;
  logic [11:0] cmd_dur;
  logic [2:0]  cmd_vol;
  logic [1:0]  active;
  logic [1:0]  done;
  logic [3:0]  level;
  logic        audio;
  logic [2:0]  active3;
  logic [2:0]  done3;
  logic [4:0]  level3;
  logic        audio3;

  square_synth_bank u_dut (
    .CLK             (clk),
    .RESET           (rst),
    .SAMPLE_TRIGGER  (trig),
    .CMD_VALID       (cmd_valid),
    .CMD_CHANNEL     (cmd_ch),
    .CMD_HALF_PERIOD (cmd_half),
    .CMD_DURATION    (cmd_dur),
    .CMD_VOLUME      (cmd_vol),
    .ACTIVE          (active),
    .DONE            (done),
    .AUDIO_LEVEL     (level),
    .AUDIO           (audio)
  );

  square_synth_bank #(.CHANNELS(3)) u_dut3 (
    .CLK             (clk),
    .RESET           (rst),
    .SAMPLE_TRIGGER  (trig),
    .CMD_VALID       (cmd_valid3),
    .CMD_CHANNEL     (cmd_ch3),
    .CMD_HALF_PERIOD (cmd_half),
    .CMD_DURATION    (cmd_dur),
    .CMD_VOLUME      (cmd_vol),
    .ACTIVE          (active3),
    .DONE            (done3),
    .AUDIO_LEVEL     (level3),
    .AUDIO           (audio3)
  );

  typedef enum int {
    K_LEVEL, K_ACT, K_DONE, K_AUDIO, K_ONES,
    K_ACT3, K_LEVEL3, K_DONE3, K_AUD3
  } kind_e;

  typedef struct {
    int    cyc;
    kind_e kind;
    int    val;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic [15:0] hist = '0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic void expect_at(
    input int c, input kind_e k, input int v);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endfunction

  initial begin
    exp_t  e;
    int    got;
    string nm;
    forever begin
      @(negedge clk);
      hist = {hist[14:0], audio};
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.kind)
          K_LEVEL:  begin got = int'(level);   nm = "level";  end
          K_ACT:    begin got = int'(active);  nm = "active"; end
          K_DONE:   begin got = int'(done);    nm = "done";   end
          K_AUDIO:  begin got = int'(audio);   nm = "audio";  end
          K_ONES:   begin got = $countones(hist); nm = "ones16"; end
          K_ACT3:   begin got = int'(active3); nm = "active3"; end
          K_LEVEL3: begin got = int'(level3);  nm = "level3"; end
          K_DONE3:  begin got = int'(done3);   nm = "done3";  end
          default:  begin got = int'(audio3);  nm = "audio3"; end
        endcase
        checks++;
        if (e.cyc == cyc && got == e.val) passes++;
        else $display("FAIL %s cycle %0d (due %0d): got %0d expected %0d",
                      nm, cyc, e.cyc, got, e.val);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    trig       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) nxt();
  endtask

  task automatic set_cmd(
    input int ch, input int h, input int d, input int v);
    cmd_valid = 1'b1;
    cmd_ch    = 1'(ch);
    cmd_half  = 16'(h);
    cmd_dur   = 12'(d);
    cmd_vol   = 3'(v);
  endtask

  task automatic set_cmd3(
    input int ch, input int h, input int d, input int v);
    cmd_valid3 = 1'b1;
    cmd_ch3    = 2'(ch);
    cmd_half   = 16'(h);
    cmd_dur    = 12'(d);
    cmd_vol    = 3'(v);
  endtask

  initial begin
    int   n, m, s, o, a, r, c, p;
    int   p0, p1;
    exp_t e;
    rst = 1'b1; trig = 1'b0;
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    cmd_ch = '0; cmd_ch3 = '0;
    cmd_half = '0; cmd_dur = '0; cmd_vol = '0;

    expect_at(4, K_ACT, 0);
    expect_at(4, K_DONE, 0);
    expect_at(4, K_LEVEL, 0);
    expect_at(4, K_AUDIO, 0);
    wait_until(3);
    checks++;
    if (active === 2'b00 && done === 2'b00) passes++;
    else $display("FAIL reset active/done: %0d %0d", active, done);
    checks++;
    if (level === 4'd0 && audio === 1'b0) passes++;
    else $display("FAIL reset level/audio: %0d %0d", level, audio);
    checks++;
    if (active3 === 3'b000 && done3 === 3'b000) passes++;
    else $display("FAIL reset active3/done3: %0d %0d", active3, done3);
    checks++;
    if (level3 === 5'd0 && audio3 === 1'b0) passes++;
    else $display("FAIL reset level3/audio3: %0d %0d", level3, audio3);
    rst = 1'b0;

    wait_until(8);
    n = cyc;
    set_cmd(0, 3, 16, 7);
    expect_at(n+1, K_ACT, 1);
    expect_at(n+1, K_LEVEL, 0);
    expect_at(n+2, K_LEVEL, 7);
    for (int k = 1; k <= 16; k++) begin
      expect_at(n+4*k+1, K_LEVEL,
        (((k-1)/4) % 2 == 0) ? 7 : 0);
      expect_at(n+4*k+2, K_LEVEL,
        ((k/4) % 2 == 0 && k < 16) ? 7 : 0);
    end
    expect_at(n+64, K_ACT, 1);
    expect_at(n+65, K_ACT, 0);
    expect_at(n+64, K_DONE, 0);
    expect_at(n+65, K_DONE, 1);
    expect_at(n+66, K_DONE, 0);
    for (int k = 1; k <= 16; k++) begin
      wait_until(n+4*k);
      trig = 1'b1;
    end

    wait_until(n+70);
    m = cyc;
    set_cmd(0, 3, 100, 7);
    expect_at(m+2, K_LEVEL, 7);
    for (int k = 1; k <= 11; k++) begin
      expect_at(m+4*k+2, K_LEVEL,
        (k < 4) ? 7 :
        ((((k-4)/2) % 2 == 0) ? 0 : 7));
    end
    for (int k = 1; k <= 11; k++) begin
      wait_until(m+4*k);
      trig = 1'b1;
      if (k == 2) begin
        wait_until(m+10);
        set_cmd(0, 1, 100, 7);
      end
    end

    s = m + 46;
    expect_at(s+1, K_ACT, 0);
    expect_at(s+1, K_DONE, 0);
    expect_at(s+2, K_DONE, 0);
    expect_at(s+1, K_LEVEL, 7);
    expect_at(s+2, K_LEVEL, 0);
    wait_until(s);
    set_cmd(0, 0, 0, 0);

    o = s + 5;
    expect_at(o+1, K_ACT3, 0);
    expect_at(o+2, K_LEVEL3, 0);
    expect_at(o+3, K_ACT3, 4);
    expect_at(o+4, K_LEVEL3, 5);
    wait_until(o);
    set_cmd3(3, 2, 10, 5);
    wait_until(o+2);
    set_cmd3(2, 2, 10, 5);

    a = o + 8;
    expect_at(a+2, K_ACT, 3);
    expect_at(a+2, K_LEVEL, 5);
    expect_at(a+3, K_LEVEL, 8);
    for (int k = 1; k <= 30; k++) begin
      p0 = ((k/3) % 2 == 0) ? 5 : 0;
      p1 = ((k/5) % 2 == 0) ? 3 : 0;
      expect_at(a+3+2*k, K_LEVEL, p0 + p1);
    end
    wait_until(a);
    set_cmd(0, 2, 100, 5);
    wait_until(a+1);
    set_cmd(1, 4, 100, 3);
    for (int k = 1; k <= 30; k++) begin
      wait_until(a+1+2*k);
      trig = 1'b1;
    end

    r = a + 65;
    expect_at(r, K_LEVEL, 8);
    expect_at(r+1, K_ACT, 0);
    expect_at(r+1, K_LEVEL, 0);
    expect_at(r+1, K_AUDIO, 0);
    expect_at(r+1, K_DONE, 0);
    expect_at(r+1, K_ACT3, 0);
    expect_at(r+1, K_DONE3, 0);
    expect_at(r+1, K_AUD3, 0);
    wait_until(r);
    rst = 1'b1;
    nxt();
    rst = 1'b0;

    c = r + 3;
    expect_at(c+1, K_ACT, 2);
    expect_at(c+7, K_ACT, 2);
    expect_at(c+7, K_DONE, 0);
    expect_at(c+15, K_ACT, 2);
    expect_at(c+16, K_ACT, 2);
    expect_at(c+17, K_ACT, 0);
    expect_at(c+17, K_DONE, 2);
    expect_at(c+18, K_DONE, 0);
    wait_until(c);
    set_cmd(1, 3, 3, 4);
    for (int t = 2; t <= 16; t += 2) begin
      wait_until(c+t);
      trig = 1'b1;
      if (t == 6) set_cmd(1, 3, 5, 4);
    end

    expect_at(c+21, K_ACT, 0);
    expect_at(c+21, K_LEVEL, 0);
    wait_until(c+20);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    p = c + 23;
    expect_at(p+2, K_LEVEL, 2);
    expect_at(p+9, K_AUDIO, 0);
    expect_at(p+10, K_AUDIO, 1);
    expect_at(p+11, K_AUDIO, 0);
    expect_at(p+20, K_ONES, 2);
    expect_at(p+33, K_ONES, 2);
    expect_at(p+50, K_ONES, 2);
    wait_until(p);
    set_cmd(0, 100, 4000, 2);
    wait_until(p+55);

    for (int i = 0; i < 200 && sb.size() > 0; i++) nxt();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      $display("FAIL timeout: check due cycle %0d never evaluated (val %0d)",
               e.cyc, e.val);
    end
    if (passes != checks)
      $display("FAIL: %0d of %0d checks failed", checks - passes, checks);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
